// File: rtl/lsu_mem_access_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Latency: none, wires only.
// Backpressure: the master holds its request until mem_gnt; read data returns on mem_rvalid.
//
// Signals:
//   mem_req    master->slave  request valid
//   mem_gnt    slave->master  request accepted this cycle
//   mem_we     master->slave  1 = write
//   mem_be     master->slave  byte enables
//   mem_addr   master->slave  word-aligned address
//   mem_wdata  master->slave  lane-replicated write data
//   mem_rvalid slave->master  read data valid (never in the same cycle as its grant)
//   mem_rdata  slave->master  read word
interface lsu_mem_access_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_gnt;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store unit: aligns stores, extracts/extends loads, flags misaligned accesses.
// Latency: store 2 cycles, load 3 cycles (accept to resp_valid, minimum), misaligned 1 cycle.
// Backpressure: busy stalls the pipeline until DONE; bus request held until mem_gnt.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req_valid      MEM-stage instruction valid (inputs stable while busy)
//   read_write     access code, bit3 = memory op
//   addr, wdata    effective byte address, store source
//   busy           pipeline stall request
//   resp_valid     one-cycle completion pulse
//   rdata          extended load data (zero for stores/faults during resp_valid)
//   misaligned     alignment fault, valid with resp_valid
//   mem            data-memory bus (master side)
module lsu_mem_access #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [3:0]       read_write,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  output logic             busy,
  output logic             resp_valid,
  output logic [XLEN-1:0]  rdata,
  output logic             misaligned,
  lsu_mem_access_if.master mem
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Decoded access: {store, unsigned, size[1:0]}
  function automatic logic [3:0] decode(input logic [2:0] code);
    logic [3:0] d;
    case (code)
      3'b000:  d = {1'b0, 1'b0, SZ_BYTE}; // lb
      3'b001:  d = {1'b0, 1'b0, SZ_HALF}; // lh
      3'b010:  d = {1'b0, 1'b0, SZ_WORD}; // lw
      3'b011:  d = {1'b1, 1'b0, SZ_BYTE}; // sb
      3'b100:  d = {1'b0, 1'b1, SZ_BYTE}; // lbu
      3'b101:  d = {1'b0, 1'b1, SZ_HALF}; // lhu
      3'b110:  d = {1'b1, 1'b0, SZ_HALF}; // sh
      default: d = {1'b1, 1'b0, SZ_WORD}; // sw
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  logic [1:0]      state;
  logic [3:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] load_q;
  logic            mis_q;

  logic [3:0]      in_dec;
  logic            in_mis;
  logic            accept;
  logic [3:0]      q_dec;
  logic            q_store;
  logic            q_uns;
  logic [1:0]      q_size;

  assign in_dec  = decode(read_write[2:0]);
  assign in_mis  = is_misaligned(in_dec[1:0], addr[1:0]);
  assign accept  = req_valid & read_write[3];

  assign q_dec   = decode(op_q[2:0]);
  assign q_store = q_dec[3];
  assign q_uns   = q_dec[2];
  assign q_size  = q_dec[1:0];

  // Bus outputs are derived from the captured access, so they stay stable
  // for the whole REQ phase regardless of what the pipeline does.
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc;

  always_comb begin
    be_calc    = 4'b0000;
    wdata_calc = '0;
    case (q_size)
      SZ_BYTE: begin
        be_calc    = 4'b0001 << addr_q[1:0];
        wdata_calc = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_calc = {2{wdata_q[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_q;
      end
    endcase
  end

  assign mem.mem_req   = (state == ST_REQ);
  assign mem.mem_we    = (state == ST_REQ) & q_store;
  // op_q is zero out of reset, which keeps the byte enables quiet until the first access.
  assign mem.mem_be    = op_q[3] ? be_calc : 4'b0000;
  assign mem.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem.mem_wdata = wdata_calc;

  // Load lane extraction from the returned word.
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    lane_byte = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = mem.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_ext  = mem.mem_rdata;
    case (q_size)
      SZ_BYTE: load_ext = q_uns ? {{(XLEN-8){1'b0}}, lane_byte}
                                : {{(XLEN-8){lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = q_uns ? {{(XLEN-16){1'b0}}, lane_half}
                                : {{(XLEN-16){lane_half[15]}}, lane_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= read_write;
            addr_q  <= addr;
            wdata_q <= wdata;
            mis_q   <= in_mis;
            // Faulting accesses go straight to the response without touching the bus.
            state   <= in_mis ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt) begin
            state <= q_store ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem.mem_rvalid) begin
            load_q <= load_ext;
            state  <= ST_DONE;
          end
        end
        default: begin
          mis_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // busy drops in DONE so the pipeline advances on the same edge that returns to IDLE.
  assign busy = ~rst & ((state == ST_REQ) | (state == ST_WAIT) |
                        ((state == ST_IDLE) & accept));

  assign resp_valid = (state == ST_DONE);
  assign misaligned = resp_valid & mis_q;

  // The last load result is kept visible; only a store or fault response reads as zero.
  assign rdata = (resp_valid & (q_store | mis_q)) ? '0 : load_q;

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store unit in the MEM stage. It consumes the 4-bit read_write access code produced by the ID-stage decode.
- It drives the data-memory bus with a request/grant plus read-valid handshake, byte-lane alignment and byte enables.
- It returns sign/zero-extended load data to writeback.
- It stalls the pipeline through `busy` until the access completes. Misaligned half/word accesses are flagged and never reach memory.

Parameters:
- XLEN, 32, data/address width (only 32 supported).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM-stage instruction valid; inputs are held stable while busy=1
- read_write  in  4  access code: bit3=memory op; 1000 lb, 1001 lh, 1010 lw, 1100 lbu, 1101 lhu, 1011 sb, 1110 sh, 1111 sw; 0xxx = no access
- addr  in  XLEN  effective byte address (ALU result)
- wdata  in  XLEN  store source (rs2)
- busy  out  1  stall request to pipeline
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  XLEN  extended load result, valid with resp_valid
- misaligned  out  1  alignment fault, valid with resp_valid
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepts request this cycle
- mem_we  out  1  1=write
- mem_be  out  4  byte enables
- mem_addr  out  XLEN  word address {addr[31:2],2'b00}
- mem_wdata  out  XLEN  lane-replicated store data
- mem_rvalid  in  1  read data valid; never in the same cycle as its mem_gnt
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset (async, any state): state=IDLE. busy, resp_valid, misaligned, mem_req and mem_we = 0. rdata, mem_be, mem_addr, mem_wdata and all captured registers = 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: accept when req_valid & read_write[3]; capture read_write, addr and wdata.
  - Misaligned access → DONE with misaligned=1 and no bus activity. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise → REQ.
  - read_write[3]=0 → stay IDLE, no response.
- REQ: mem_req=1 with mem_we/mem_be/mem_addr/mem_wdata stable until mem_gnt.
  - On gnt: store → DONE; load → WAIT.
- WAIT: on mem_rvalid capture the extended result → DONE.
- DONE: resp_valid=1 for exactly one cycle → IDLE.
- busy = (state==REQ) | (state==WAIT) | (state==IDLE & req_valid & read_write[3]). busy=0 in DONE, so the pipeline advances on the DONE edge.
- mem_rvalid in IDLE/REQ/DONE is ignored; this covers stale data after a reset mid-transaction.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - Loads drive mem_be too.
- Store data: sb replicates wdata[7:0] ×4; sh replicates wdata[15:0] ×2; sw passes wdata.
- Load extraction: select the byte/half at addr[1:0]/addr[1] from mem_rdata. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- rdata holds its value until the next load completes. Stores and faults force rdata=0 during their resp_valid.
- Latency: store accept→resp_valid = 2 cycles minimum (gnt in REQ's first cycle). Load = 3 cycles minimum. Misaligned = 1 cycle.
- No pipelining: at most one outstanding transaction.

Test Plan:
- sb, addr 0x00000103, wdata 0x000000AB, gnt immediate → mem_addr 0x00000100, mem_be 1000, mem_wdata 0xABABABAB, mem_we=1; resp_valid 2 cycles after accept; busy high for exactly 2 cycles.
- lb, addr 0x102, mem_rdata 0x12803456 → rdata 0xFFFFFF80. lbu at the same address → 0x00000080. lhu, addr 0x102 → 0x00001280; lh → 0x00001280.
- lw, addr 0x200, mem_gnt delayed 3 cycles, mem_rvalid 2 cycles after gnt with 0xDEADBEEF → mem_req held 4 cycles with stable outputs; busy held continuously; rdata 0xDEADBEEF with a single resp_valid pulse.
- sh, addr 0x201 → resp_valid and misaligned=1 the cycle after accept; mem_req never asserted. lw at 0x202 behaves the same.
- Load in WAIT, rst asserted mid-cycle → outputs zero immediately. Late mem_rvalid after reset produces no resp_valid.
- read_write=0000 with req_valid=1 → busy=0, no mem_req, no resp_valid. Back-to-back sw then lw → second accepted in the cycle after DONE.
